tdm_demux_1to8: RTL and testbench

//  Receive-side counterpart of the 8:1 selector: one time-multiplexed word stream in, eight

---
 rtl/tdm_demux_1to8_pkg.sv | 20 ++
 rtl/tdm_slot_ctr.sv | 32 +++
 rtl/tdm_demux_1to8.sv | 135 +++++++++++++
 tb/tb_tdm_demux_1to8.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_1to8_pkg.sv
// Shared definitions for the TDM link: lane count, slot width, FSM state codes.
// The matching TDM transmitter imports the same package.
package tdm_demux_1to8_pkg;

   localparam int NUM_LANES = 8;
   localparam int SLOT_W    = 3;

   localparam logic [SLOT_W-1:0] SLOT_FIRST = 3'd0;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = 3'd7;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_LOCK = 1'b1
   } tdm_state_e;

   function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SLOT_W-1:0] slot);
      return NUM_LANES'(1) << slot;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// 3-bit slot counter: clear, load-to-1 (slot 0 just written), increment with natural
// wrap 7->0, and a flag marking the last slot of the frame.
module tdm_slot_ctr
   import tdm_demux_1to8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_i,
   input  logic              load1_i,
   input  logic              clr_i,
   output logic [SLOT_W-1:0] slot_o,
   output logic              last_o
);

   logic [SLOT_W-1:0] slot_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= SLOT_FIRST;
      end else if (clr_i) begin
         slot_q <= SLOT_FIRST;
      end else if (load1_i) begin
         slot_q <= SLOT_W'(1);
      end else if (inc_i) begin
         slot_q <= slot_q + 1'b1;
      end
   end

   assign slot_o = slot_q;
   assign last_o = (slot_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux_1to8.sv
// 1:8 TDM demultiplexer: aligns on the start-of-frame marker and distributes the
// word stream into eight registered lanes with per-lane update pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HUNT | waiting for a word flagged in_sof; all other words dropped
// ST_LOCK | aligned; slot counter tracks the position in the frame
module tdm_demux_1to8
   import tdm_demux_1to8_pkg::*;
#(
   parameter int W          = 8,
   parameter int CNT_W      = 16,
   parameter bit STRICT_SOF = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [W-1:0]           in_data,
   input  logic                   in_sof,
   output logic [NUM_LANES*W-1:0] lane_data,
   output logic [NUM_LANES-1:0]   lane_valid,
   output logic                   frame_done,
   output logic                   sync_err,
   output logic                   locked,
   output logic [CNT_W-1:0]       frame_count
);

   tdm_state_e             state_q, state_d;
   logic [NUM_LANES*W-1:0] lane_data_q;
   logic [NUM_LANES-1:0]   lane_valid_q;
   logic                   frame_done_q;
   logic                   sync_err_q;
   logic                   locked_q;
   logic [CNT_W-1:0]       frame_count_q;

   logic [SLOT_W-1:0]      slot;
   logic                   slot_last;
   logic                   slot_inc, slot_load1, slot_clr;

   logic                   wr_en;
   logic [SLOT_W-1:0]      wr_slot;
   logic                   done_d;
   logic                   err_d;

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (slot_inc),
      .load1_i (slot_load1),
      .clr_i   (slot_clr),
      .slot_o  (slot),
      .last_o  (slot_last)
   );

   always_comb begin
      state_d    = state_q;
      wr_en      = 1'b0;
      wr_slot    = slot;
      slot_inc   = 1'b0;
      slot_load1 = 1'b0;
      slot_clr   = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (in_sof) begin
                  wr_en      = 1'b1;
                  wr_slot    = SLOT_FIRST;
                  slot_load1 = 1'b1;
                  state_d    = ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (in_sof) begin
                  // early SOF restarts the frame; lanes beyond the cut keep stale data
                  err_d      = (slot != SLOT_FIRST);
                  wr_en      = 1'b1;
                  wr_slot    = SLOT_FIRST;
                  slot_load1 = 1'b1;
               end else if (slot == SLOT_FIRST) begin
                  if (STRICT_SOF) begin
                     err_d    = 1'b1;
                     slot_clr = 1'b1;
                     state_d  = ST_HUNT;
                  end else begin
                     wr_en      = 1'b1;
                     wr_slot    = SLOT_FIRST;
                     slot_load1 = 1'b1;
                  end
               end else begin
                  wr_en    = 1'b1;
                  slot_inc = 1'b1;
                  done_d   = slot_last;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_HUNT;
         lane_data_q   <= '0;
         lane_valid_q  <= '0;
         frame_done_q  <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lane_valid_q <= wr_en ? lane_onehot(wr_slot) : '0;
         frame_done_q <= done_d;
         sync_err_q   <= err_d;
         locked_q     <= (state_d == ST_LOCK);
         if (done_d) begin
            frame_count_q <= frame_count_q + 1'b1;
         end
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en && (wr_slot == SLOT_W'(i))) begin
               lane_data_q[i*W +: W] <= in_data;
            end
         end
      end
   end

   assign lane_data   = lane_data_q;
   assign lane_valid  = lane_valid_q;
   assign frame_done  = frame_done_q;
   assign sync_err    = sync_err_q;
   assign locked      = locked_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed bench for tdm_demux_1to8: a strict instance (CNT_W=16) and a lenient
// instance (STRICT_SOF=0, CNT_W=4) share one stimulus stream.
module tb_tdm_demux_1to8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_sof = 1'b0;

   logic [63:0] ld1, ld2;
   logic [7:0]  lv1, lv2;
   logic        fd1, fd2, se1, se2, lk1, lk2;
   logic [15:0] fc1;
   logic [3:0]  fc2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tdm_demux_1to8 #(.W(8), .CNT_W(16), .STRICT_SOF(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
      .lane_data(ld1), .lane_valid(lv1), .frame_done(fd1), .sync_err(se1),
      .locked(lk1), .frame_count(fc1)
   );

   tdm_demux_1to8 #(.W(8), .CNT_W(4), .STRICT_SOF(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
      .lane_data(ld2), .lane_valid(lv2), .frame_done(fd2), .sync_err(se2),
      .locked(lk2), .frame_count(fc2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive on the falling edge, return 1 time unit after the next rising edge
   task automatic send(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pulses1(input string tag, input logic [7:0] lv, input logic fd,
                              input logic se, input logic lk);
      chk({tag, ".lv1"}, 64'(lv1), 64'(lv));
      chk({tag, ".fd1"}, 64'(fd1), 64'(fd));
      chk({tag, ".se1"}, 64'(se1), 64'(se));
      chk({tag, ".lk1"}, 64'(lk1), 64'(lk));
   endtask

   task automatic chk_pulses2(input string tag, input logic [7:0] lv, input logic fd,
                              input logic se, input logic lk);
      chk({tag, ".lv2"}, 64'(lv2), 64'(lv));
      chk({tag, ".fd2"}, 64'(fd2), 64'(fd));
      chk({tag, ".se2"}, 64'(se2), 64'(se));
      chk({tag, ".lk2"}, 64'(lk2), 64'(lk));
   endtask

   task automatic chk_zero(input string tag);
      chk_pulses1(tag, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_pulses2(tag, 8'h00, 1'b0, 1'b0, 1'b0);
      chk({tag, ".ld1"}, ld1, 64'h0);
      chk({tag, ".ld2"}, ld2, 64'h0);
      chk({tag, ".fc1"}, 64'(fc1), 64'h0);
      chk({tag, ".fc2"}, 64'(fc2), 64'h0);
   endtask

   initial begin
      // 1: reset with random inputs, then non-SOF words after release
      for (int i = 0; i < 4; i++) begin
         send(1'($urandom), 1'($urandom), 8'($urandom));
         chk_zero("rst_hold");
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 1'b0, 8'($urandom));
         chk_zero("hunt_drop");
      end

      // 2: clean frame
      send(1'b1, 1'b1, 8'h10);
      chk_pulses1("clean_s0", 8'h01, 1'b0, 1'b0, 1'b1);
      chk("clean_s0.ld1", ld1, 64'h0000000000000010);
      for (int i = 1; i < 8; i++) begin
         send(1'b1, 1'b0, 8'(8'h10 + i));
         chk_pulses1("clean_walk", 8'(1 << i), (i == 7), 1'b0, 1'b1);
         chk_pulses2("clean_walk2", 8'(1 << i), (i == 7), 1'b0, 1'b1);
      end
      chk("clean.ld1", ld1, 64'h1716151413121110);
      chk("clean.fc1", 64'(fc1), 64'd1);
      chk("clean.fc2", 64'(fc2), 64'd1);
      send(1'b0, 1'b0, 8'hFF);
      chk_pulses1("clean_idle", 8'h00, 1'b0, 1'b0, 1'b1);

      // 3: gapped frame
      send(1'b1, 1'b1, 8'h10);
      send(1'b1, 1'b0, 8'h11);
      send(1'b1, 1'b0, 8'h12);
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 1'b1, 8'hEE);
         chk_pulses1("gap_idle", 8'h00, 1'b0, 1'b0, 1'b1);
      end
      send(1'b1, 1'b0, 8'h13);
      chk_pulses1("gap_s3", 8'h08, 1'b0, 1'b0, 1'b1);
      for (int i = 4; i < 8; i++) send(1'b1, 1'b0, 8'(8'h10 + i));
      chk_pulses1("gap_s7", 8'h80, 1'b1, 1'b0, 1'b1);
      chk("gap.ld1", ld1, 64'h1716151413121110);
      chk("gap.fc1", 64'(fc1), 64'd2);

      // 4: early SOF after slot 4
      send(1'b1, 1'b1, 8'h20);
      for (int i = 1; i < 5; i++) send(1'b1, 1'b0, 8'(8'h20 + i));
      chk("early_pre.ld1", ld1, 64'h1716152423222120);
      send(1'b1, 1'b1, 8'hA0);
      chk_pulses1("early_sof", 8'h01, 1'b0, 1'b1, 1'b1);
      chk_pulses2("early_sof2", 8'h01, 1'b0, 1'b1, 1'b1);
      chk("early.ld1", ld1, 64'h17161524232221A0);
      chk("early.fc1", 64'(fc1), 64'd2);
      send(1'b1, 1'b0, 8'hB1);
      chk_pulses1("early_next", 8'h02, 1'b0, 1'b0, 1'b1);
      for (int i = 2; i < 8; i++) send(1'b1, 1'b0, 8'(8'hB0 + i));
      chk("early_done.ld1", ld1, 64'hB7B6B5B4B3B2B1A0);
      chk("early_done.fc1", 64'(fc1), 64'd3);
      chk("early_done.fc2", 64'(fc2), 64'd3);

      // 5: missing SOF at slot 0
      send(1'b1, 1'b0, 8'h55);
      chk_pulses1("nosof", 8'h00, 1'b0, 1'b1, 1'b0);
      chk("nosof.ld1", ld1, 64'hB7B6B5B4B3B2B1A0);
      chk_pulses2("nosof2", 8'h01, 1'b0, 1'b0, 1'b1);
      chk("nosof.ld2", ld2, 64'hB7B6B5B4B3B2B155);
      send(1'b1, 1'b0, 8'h66);
      chk_pulses1("nosof_drop", 8'h00, 1'b0, 1'b0, 1'b0);
      chk("nosof_drop.ld1", ld1, 64'hB7B6B5B4B3B2B1A0);
      chk("nosof_drop.ld2", ld2, 64'hB7B6B5B4B3B26655);
      send(1'b1, 1'b1, 8'h70);
      chk_pulses1("relock", 8'h01, 1'b0, 1'b0, 1'b1);
      chk("relock.ld1", ld1, 64'hB7B6B5B4B3B2B170);
      chk_pulses2("relock2", 8'h01, 1'b0, 1'b1, 1'b1);
      chk("relock.ld2", ld2, 64'hB7B6B5B4B3B26670);

      // 6a: reset mid-frame clears outputs without a clock edge
      send(1'b1, 1'b0, 8'h71);
      send(1'b1, 1'b0, 8'h72);
      send(1'b1, 1'b0, 8'h73);
      chk("mid.lv1", 64'(lv1), 64'h08);
      #1 rst_n = 1'b0;
      #1 chk_zero("mid_rst");
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      send(1'b1, 1'b0, 8'h74);
      chk_zero("mid_rel");

      // 6b: 16 frames, 4-bit counter wraps 15 -> 0
      for (int f = 0; f < 16; f++) begin
         send(1'b1, 1'b1, 8'(f));
         for (int s = 1; s < 8; s++) send(1'b1, 1'b0, 8'(f * 8 + s));
         if (f == 14) begin
            chk("wrap15.fc1", 64'(fc1), 64'd15);
            chk("wrap15.fc2", 64'(fc2), 64'd15);
         end
      end
      chk("wrap.fc1", 64'(fc1), 64'd16);
      chk("wrap.fc2", 64'(fc2), 64'd0);
      chk_pulses2("wrap_last", 8'h80, 1'b1, 1'b0, 1'b1);
      chk("wrap.ld2", ld2, 64'h7F7E7D7C7B7A790F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
